// File: rtl/snake_draw_pkg.sv
// Shared definitions for the snake drawing arbiter: FSM state encoding,
// palette constants and the cell geometry.
package snake_draw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        DONE  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;

    // A cell is 2x2 pixels, painted in raster order.
    localparam int unsigned CELL_PIXELS = 4;

endpackage

// File: rtl/snake_rr_select.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping modulo NUM_REQ.
module snake_rr_select #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   idx
);

    // Scan from ptr upward and keep the first hit.
    always_comb begin
        int unsigned j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (32'(ptr) + i) % NUM_REQ;
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/snake_draw_arbiter.sv
// Round-robin arbiter sharing the VGA plot port between drawing requesters.
// Each grant paints one 2x2 cell. Optional full-screen clear sequencer is
// built when SNAKE_DRAW_CLEAR_EN is defined.
module snake_draw_arbiter
    import snake_draw_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*3-1:0]   req_colour,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic                   busy
`ifdef SNAKE_DRAW_CLEAR_EN
    ,
    input  logic                   clear_req,
    output logic                   clear_done
`endif
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_n;
    logic [1:0]           cnt;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     k;
    logic [X_W-1:0]       x_l;
    logic [Y_W-1:0]       y_l;
    logic [2:0]           c_l;
    logic [NUM_REQ-1:0]   grant_r;
    logic                 sel_valid;
    logic [PTR_W-1:0]     sel_idx;
`ifdef SNAKE_DRAW_CLEAR_EN
    logic [X_W-1:0]       cx;
    logic [Y_W-1:0]       cy;
    logic                 clr_last;
`endif

    snake_rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_select (
        .req   (req),
        .ptr   (ptr),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next-state logic and registered-state output decode.
    always_comb begin
        state_n    = state;
        grant      = grant_r;
        done       = '0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        busy       = (state != IDLE);
`ifdef SNAKE_DRAW_CLEAR_EN
        clear_done = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef SNAKE_DRAW_CLEAR_EN
                if (clear_req)      state_n = CLEAR;
                else if (sel_valid) state_n = DRAW;
`else
                if (sel_valid) state_n = DRAW;
`endif
            end
            DRAW: begin
                vga_plot   = 1'b1;
                vga_colour = c_l;
                vga_x      = x_l + X_W'(cnt[0]);
                vga_y      = y_l + Y_W'(cnt[1]);
                if (cnt == 2'(CELL_PIXELS - 1)) state_n = DONE;
            end
            DONE: begin
                done    = grant_r;
                state_n = IDLE;
            end
`ifdef SNAKE_DRAW_CLEAR_EN
            CLEAR: begin
                if (clr_last) begin
                    clear_done = 1'b1;
                    state_n    = IDLE;
                end else begin
                    vga_plot   = 1'b1;
                    vga_colour = BLACK;
                    vga_x      = cx;
                    vga_y      = cy;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Datapath: latch request data at grant, step the pixel counter,
    // advance the round-robin pointer and run the clear scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            ptr      <= '0;
            k        <= '0;
            x_l      <= '0;
            y_l      <= '0;
            c_l      <= '0;
            grant_r  <= '0;
`ifdef SNAKE_DRAW_CLEAR_EN
            cx       <= '0;
            cy       <= '0;
            clr_last <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (state_n == DRAW) begin
                        x_l     <= req_x[int'(sel_idx)*X_W +: X_W];
                        y_l     <= req_y[int'(sel_idx)*Y_W +: Y_W];
                        c_l     <= req_colour[int'(sel_idx)*3 +: 3];
                        grant_r <= NUM_REQ'(1) << sel_idx;
                        k       <= sel_idx;
                        cnt     <= '0;
                    end
`ifdef SNAKE_DRAW_CLEAR_EN
                    if (state_n == CLEAR) begin
                        cx       <= '0;
                        cy       <= '0;
                        clr_last <= 1'b0;
                    end
`endif
                end
                DRAW: cnt <= cnt + 2'd1;
                DONE: begin
                    grant_r <= '0;
                    ptr     <= (k == PTR_W'(NUM_REQ - 1)) ? '0 : k + PTR_W'(1);
                end
`ifdef SNAKE_DRAW_CLEAR_EN
                CLEAR: begin
                    if (!clr_last) begin
                        if (cx == X_W'(SCREEN_W - 1)) begin
                            cx <= '0;
                            if (cy == Y_W'(SCREEN_H - 1)) clr_last <= 1'b1;
                            else                          cy <= cy + Y_W'(1);
                        end else begin
                            cx <= cx + X_W'(1);
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_draw_arbiter.sv
// Directed self-checking bench for snake_draw_arbiter (default build; the
// clear scenario is compiled only when SNAKE_DRAW_CLEAR_EN is defined).
module tb_snake_draw_arbiter;

    localparam int NR = 3;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR*8-1:0] req_x;
    logic [NR*7-1:0] req_y;
    logic [NR*3-1:0] req_colour;
    logic [NR-1:0] grant;
    logic [NR-1:0] done;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot;
    logic          busy;
`ifdef SNAKE_DRAW_CLEAR_EN
    logic          clear_req;
    logic          clear_done;
`endif

    int n_cmp = 0;
    int n_err = 0;

    snake_draw_arbiter #(
        .NUM_REQ  (NR),
        .X_W      (8),
        .Y_W      (7),
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .grant      (grant),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
`ifdef SNAKE_DRAW_CLEAR_EN
        ,
        .clear_req  (clear_req),
        .clear_done (clear_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b0;
        req = '0;
        req_x = '0;
        req_y = '0;
        req_colour = '0;
`ifdef SNAKE_DRAW_CLEAR_EN
        clear_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({grant, done, vga_x, vga_y, vga_colour, vga_plot, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got grant=%b done=%b x=%0d y=%0d c=%b plot=%b busy=%b want all 0",
                     grant, done, vga_x, vga_y, vga_colour, vga_plot, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, vga_plot} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b plot=%b want 0 0", busy, vga_plot);
        end
    endtask

    task automatic test_single;
        logic [7:0] ex [4];
        logic [6:0] ey [4];
        ex[0] = 8'd10; ex[1] = 8'd11; ex[2] = 8'd10; ex[3] = 8'd11;
        ey[0] = 7'd20; ey[1] = 7'd20; ey[2] = 7'd21; ey[3] = 7'd21;
        req_x[8 +: 8]      = 8'd10;
        req_y[7 +: 7]      = 7'd20;
        req_colour[3 +: 3] = 3'b010;
        req = 3'b010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({vga_plot, vga_x, vga_y, vga_colour, grant, busy} !== {1'b1, ex[i], ey[i], 3'b010, 3'b010, 1'b1}) begin
                n_err++;
                $display("FAIL single_plot%0d: got plot=%b (%0d,%0d) c=%b grant=%b busy=%b want 1 (%0d,%0d) c=010 grant=010 busy=1",
                         i, vga_plot, vga_x, vga_y, vga_colour, grant, busy, ex[i], ey[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done, vga_plot, grant} !== {3'b010, 1'b0, 3'b010}) begin
            n_err++;
            $display("FAIL single_done: got done=%b plot=%b grant=%b want 010 0 010", done, vga_plot, grant);
        end
        req = '0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, grant} !== 7'b0) begin
            n_err++;
            $display("FAIL single_idle: got busy=%b done=%b grant=%b want 0 000 000", busy, done, grant);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] ex [4];
        logic [6:0] ey [4];
        ex[0] = 8'd255; ex[1] = 8'd0;   ex[2] = 8'd255; ex[3] = 8'd0;
        ey[0] = 7'd127; ey[1] = 7'd127; ey[2] = 7'd0;   ey[3] = 7'd0;
        req_x[0 +: 8]      = 8'd255;
        req_y[0 +: 7]      = 7'd127;
        req_colour[0 +: 3] = 3'b100;
        req = 3'b001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, ex[i], ey[i], 3'b100}) begin
                n_err++;
                $display("FAIL wrap_plot%0d: got plot=%b (%0d,%0d) c=%b want 1 (%0d,%0d) c=100",
                         i, vga_plot, vga_x, vga_y, vga_colour, ex[i], ey[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 3'b001) begin
            n_err++;
            $display("FAIL wrap_done: got %b want 001", done);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_stability;
        logic [7:0] ex [4];
        logic [6:0] ey [4];
        ex[0] = 8'd50; ex[1] = 8'd51; ex[2] = 8'd50; ex[3] = 8'd51;
        ey[0] = 7'd60; ey[1] = 7'd60; ey[2] = 7'd61; ey[3] = 7'd61;
        req_x[16 +: 8]     = 8'd50;
        req_y[14 +: 7]     = 7'd60;
        req_colour[6 +: 3] = 3'b010;
        req = 3'b100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, ex[i], ey[i], 3'b010}) begin
                n_err++;
                $display("FAIL stable_plot%0d: got plot=%b (%0d,%0d) c=%b want 1 (%0d,%0d) c=010",
                         i, vga_plot, vga_x, vga_y, vga_colour, ex[i], ey[i]);
            end
            req_x[16 +: 8]     = 8'd99;
            req_y[14 +: 7]     = 7'd5;
            req_colour[6 +: 3] = 3'b111;
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 3'b100) begin
            n_err++;
            $display("FAIL stable_done: got %b want 100", done);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_contention;
        logic [NR-1:0] gexp [4];
        gexp[0] = 3'b001; gexp[1] = 3'b010; gexp[2] = 3'b100; gexp[3] = 3'b001;
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            n_cmp++;
            if ({grant, vga_plot} !== {gexp[g], 1'b1}) begin
                n_err++;
                $display("FAIL contention_grant%0d: got grant=%b plot=%b want %b 1", g, grant, vga_plot, gexp[g]);
            end
            repeat (4) @(negedge clk);
            n_cmp++;
            if (done !== gexp[g]) begin
                n_err++;
                $display("FAIL contention_done%0d: got %b want %b", g, done, gexp[g]);
            end
            if (g == 3) req = '0;
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL contention_gap%0d: got busy=%b want 0", g, busy);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, grant} !== 4'b0) begin
            n_err++;
            $display("FAIL contention_quiet: got busy=%b grant=%b want 0 000", busy, grant);
        end
    endtask

    task automatic test_reset_mid;
        req_x[0 +: 8] = 8'd30;
        req_y[0 +: 7] = 7'd40;
        req_colour[0 +: 3] = 3'b100;
        req = 3'b001;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({grant, done, vga_x, vga_y, vga_colour, vga_plot, busy} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got grant=%b done=%b x=%0d y=%0d c=%b plot=%b busy=%b want all 0",
                     grant, done, vga_x, vga_y, vga_colour, vga_plot, busy);
        end
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 4'b0) begin
            n_err++;
            $display("FAIL midreset_nodone: got done=%b busy=%b want 000 0", done, busy);
        end
        req_x[16 +: 8] = 8'd70;
        req_y[14 +: 7] = 7'd80;
        req_colour[6 +: 3] = 3'b010;
        req = 3'b101;
        @(negedge clk);
        n_cmp++;
        if (grant !== 3'b001) begin
            n_err++;
            $display("FAIL midreset_ptr0: got grant=%b want 001", grant);
        end
        repeat (5) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({grant, vga_x, vga_y} !== {3'b100, 8'd70, 7'd80}) begin
            n_err++;
            $display("FAIL midreset_req2: got grant=%b (%0d,%0d) want 100 (70,80)", grant, vga_x, vga_y);
        end
        req = '0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (done !== 3'b100) begin
            n_err++;
            $display("FAIL midreset_done2: got %b want 100", done);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef SNAKE_DRAW_CLEAR_EN
    task automatic test_clear;
        int bad_plot;
        bad_plot = 0;
        req_x[0 +: 8] = 8'd5;
        req_y[0 +: 7] = 7'd6;
        req_colour[0 +: 3] = 3'b100;
        clear_req = 1'b1;
        req = 3'b001;
        for (int i = 0; i < 19200; i++) begin
            @(negedge clk);
            clear_req = 1'b0;
            if (i == 0) begin
                n_cmp++;
                if ({vga_plot, vga_x, vga_y, vga_colour, grant} !== {1'b1, 8'd0, 7'd0, 3'b000, 3'b000}) begin
                    n_err++;
                    $display("FAIL clear_first: got plot=%b (%0d,%0d) c=%b grant=%b want 1 (0,0) 000 000",
                             vga_plot, vga_x, vga_y, vga_colour, grant);
                end
            end
            if (i == 19199) begin
                n_cmp++;
                if ({vga_plot, vga_x, vga_y} !== {1'b1, 8'd159, 7'd119}) begin
                    n_err++;
                    $display("FAIL clear_last: got plot=%b (%0d,%0d) want 1 (159,119)", vga_plot, vga_x, vga_y);
                end
            end
            if (vga_plot !== 1'b1 || vga_colour !== 3'b000 || clear_done !== 1'b0) bad_plot++;
        end
        n_cmp++;
        if (bad_plot !== 0) begin
            n_err++;
            $display("FAIL clear_scan: got %0d bad cycles want 0", bad_plot);
        end
        @(negedge clk);
        n_cmp++;
        if ({clear_done, vga_plot, grant} !== {1'b1, 1'b0, 3'b000}) begin
            n_err++;
            $display("FAIL clear_done: got done=%b plot=%b grant=%b want 1 0 000", clear_done, vga_plot, grant);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, clear_done} !== 2'b00) begin
            n_err++;
            $display("FAIL clear_idle: got busy=%b done=%b want 0 0", busy, clear_done);
        end
        @(negedge clk);
        n_cmp++;
        if ({grant, vga_x, vga_y} !== {3'b001, 8'd5, 7'd6}) begin
            n_err++;
            $display("FAIL clear_then_grant: got grant=%b (%0d,%0d) want 001 (5,6)", grant, vga_x, vga_y);
        end
        req = '0;
        repeat (6) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_stability();
        test_contention();
        test_reset_mid();
`ifdef SNAKE_DRAW_CLEAR_EN
        test_clear();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snake_draw_arbiter.md
# snake_draw_arbiter

Shares the single VGA plot port between the game's drawing requesters: snake movement, food placement and score/HUD. Each granted request paints one 2x2 cell. Requesters are served round-robin, one cell at a time, and the block drives the plotter's x/y/colour/plot inputs directly. An optional full-screen clear sequencer takes priority over all requesters.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- SCREEN_W, 160, clear-scan width in pixels
- SCREEN_H, 120, clear-scan height in pixels

- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester request level
- req_x  in  NUM_REQ*X_W  packed cell origin x; requester i uses slice i
- req_y  in  NUM_REQ*Y_W  packed cell origin y
- req_colour  in  NUM_REQ*3  packed cell colour
- grant  out  NUM_REQ  one-hot; high from the first plot cycle through the done cycle
- done  out  NUM_REQ  one-cycle pulse to the served requester
- vga_x  out  X_W  plot x
- vga_y  out  Y_W  plot y
- vga_colour  out  3  plot colour
- vga_plot  out  1  plot strobe
- busy  out  1  high in every state except IDLE
- clear_req  in  1  start full-screen clear (only with SNAKE_DRAW_CLEAR_EN)
- clear_done  out  1  one-cycle pulse at clear end (only with SNAKE_DRAW_CLEAR_EN)

## Operation
- States: IDLE, DRAW, DONE, plus CLEAR when the clear macro is defined.
- IDLE
  - Selects the first asserted req at or after the pointer `ptr`, wrapping modulo NUM_REQ.
  - On the next edge, latches that requester's x/y/colour, sets grant[k], sets cnt=0 and enters DRAW.
  - No request pending: stays in IDLE.
- DRAW
  - vga_plot=1 and vga_colour = the latched colour.
  - vga_x = x + cnt[0] and vga_y = y + cnt[1], both truncated to width, so they wrap modulo 2^W with no clipping.
  - cnt increments each cycle; after cnt=3 the block moves to DONE.
- DONE
  - done[k]=1, vga_plot=0.
  - ptr becomes (k+1) mod NUM_REQ; next state is IDLE.
- Requester contract
  - Hold req and its data stable until done.
  - The block latches data at grant, so later changes are ignored.
  - Dropping req mid-transaction does not abort it.
  - A requester must drop req in the cycle after done, or it is re-queued.
- Simultaneous requests: round-robin order from ptr; nothing is lost.
- Reset, including mid-transaction
  - State goes to IDLE, ptr=0, cnt=0.
  - All outputs are 0: grant, done, vga_x, vga_y, vga_colour, vga_plot, busy, clear_done.
  - No done is issued for an aborted transaction.

## Timing
- req seen in IDLE at edge t: grant and vga_plot go high after t; plot cycles are t..t+3, done in t+4, IDLE in t+5.
- A second pending request is granted at the edge ending t+5, giving 6 cycles per cell at full load.
- Worst-case wait for one requester: (NUM_REQ-1)*6 cycles.
- All outputs are registered-state decodes; there is no combinational path from req to vga_*.

## Configuration
- SNAKE_DRAW_CLEAR_EN defined
  - clear_req sampled in IDLE has priority over any req.
  - The block enters CLEAR and raster-scans y=0..SCREEN_H-1, x=0..SCREEN_W-1, one pixel per cycle, with colour 3'b000 and vga_plot=1.
  - The cycle after the last pixel pulses clear_done and returns to IDLE.
  - Total time is SCREEN_W*SCREEN_H+1 cycles. ptr is unchanged and grant stays 0.
- SNAKE_DRAW_CLEAR_EN undefined
  - clear_req and clear_done ports are absent and the CLEAR state and scan counters are not built.

## Structure
- Package snake_draw_pkg holds:
  - state encodings (IDLE, DRAW, DONE, CLEAR)
  - colour constants BLACK=3'b000, RED=3'b100, GREEN=3'b010
  - CELL_PIXELS=4
- Sub-module snake_rr_select: combinational round-robin picker. Inputs req and ptr; outputs valid and index k.

## Test plan
- Single request: req[1] with x=10, y=20, colour=3'b010 gives plots (10,20), (11,20), (10,21), (11,21), then done[1] on the 5th cycle and busy low on the 6th.
- Contention: req=3'b111 held continuously gives grant order 0,1,2,0 at 6-cycle spacing.
- Wrap: x=255, y=127 plots (255,127), (0,127), (255,0), (0,0).
- Reset mid-DRAW: rst low at cnt=2 forces all outputs to 0 immediately; after release, req[2] is served with ptr=0 ordering and no done is issued for the aborted cell.
- Clear (macro defined): clear_req together with req[0] runs a 19200-cycle black scan ending at (159,119) and pulses clear_done; req[0] is then granted 1 cycle later.
- Data stability: change req_x after grant and confirm plots use the latched value.
